// File: rtl/pipe_stage_reg.sv
// Elastic valid/ready pipeline-stage register with an optional skid entry.
// SKID=1 gives two entries and a registered in_ready; SKID=0 gives one entry.
module pipe_stage_reg #(
    parameter int unsigned      WIDTH     = 32,
    parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b0}},
    parameter bit               SKID      = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [1:0]       occupancy
);

    logic             r_main_v;
    logic             r_skid_v;
    logic [WIDTH-1:0] r_main_d;
    logic [WIDTH-1:0] r_skid_d;

    logic             w_in_ready;
    logic             w_in_fire;
    logic             w_out_fire;
    logic             w_main_v_nxt;
    logic             w_skid_v_nxt;
    logic [WIDTH-1:0] w_main_d_nxt;
    logic [WIDTH-1:0] w_skid_d_nxt;

    // With a skid entry in_ready depends only on state; without one it looks through to out_ready.
    always_comb begin
        if (SKID) begin
            w_in_ready = ~r_skid_v;
        end else begin
            w_in_ready = ~r_main_v | out_ready;
        end
    end

    assign w_in_fire  = in_valid & w_in_ready & ~flush;
    assign w_out_fire = r_main_v & out_ready;

    always_comb begin
        // NOTE: every next-state signal takes its hold value first so no path leaves it unassigned and infers a latch.
        w_main_v_nxt = r_main_v;
        w_skid_v_nxt = r_skid_v;
        w_main_d_nxt = r_main_d;
        w_skid_d_nxt = r_skid_d;
        if (!r_main_v) begin
            if (w_in_fire) begin
                w_main_v_nxt = 1'b1;
                w_main_d_nxt = in_data;
            end
        end else if (!r_skid_v) begin
            if (w_in_fire && w_out_fire) begin
                w_main_d_nxt = in_data;
            end else if (w_in_fire && SKID) begin
                w_skid_v_nxt = 1'b1;
                w_skid_d_nxt = in_data;
            end else if (w_out_fire) begin
                w_main_v_nxt = 1'b0;
                w_main_d_nxt = RESET_VAL;
            end
        end else if (w_out_fire) begin
            w_main_d_nxt = r_skid_d;
            w_skid_v_nxt = 1'b0;
            w_skid_d_nxt = RESET_VAL;
        end
    end

    // Reset and flush both collapse the stage to an empty bubble carrying RESET_VAL.
    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
        if (rst || flush) begin
            r_main_v <= 1'b0;
            r_skid_v <= 1'b0;
            r_main_d <= RESET_VAL;
            r_skid_d <= RESET_VAL;
        end else begin
            r_main_v <= w_main_v_nxt;
            r_skid_v <= w_skid_v_nxt;
            r_main_d <= w_main_d_nxt;
            r_skid_d <= w_skid_d_nxt;
        end
    end

    assign in_ready  = w_in_ready;
    assign out_valid = r_main_v;
    assign out_data  = r_main_d;
    assign occupancy = {1'b0, r_main_v} + {1'b0, r_skid_v};

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: three instances (SKID=1, SKID=0, 16-bit with RESET_VAL=0xDEAD)
// checked every cycle against a bounded-FIFO model, plus directed literal expectations.
module tb_pipe_stage_reg;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic [2:0]  flush;
    logic [2:0]  in_valid;
    logic [2:0]  out_ready;
    logic [31:0] in_data [3];

    logic        rdy0, rdy1, rdy2;
    logic        ov0, ov1, ov2;
    logic [31:0] od0, od1;
    logic [15:0] od2;
    logic [1:0]  occ0, occ1, occ2;

    pipe_stage_reg #(.WIDTH(32), .RESET_VAL(32'h0), .SKID(1'b1)) u_dut_s1 (
        .clk(clk), .rst(rst), .flush(flush[0]),
        .in_valid(in_valid[0]), .in_ready(rdy0), .in_data(in_data[0]),
        .out_valid(ov0), .out_ready(out_ready[0]), .out_data(od0), .occupancy(occ0)
    );

    pipe_stage_reg #(.WIDTH(32), .RESET_VAL(32'h0), .SKID(1'b0)) u_dut_s0 (
        .clk(clk), .rst(rst), .flush(flush[1]),
        .in_valid(in_valid[1]), .in_ready(rdy1), .in_data(in_data[1]),
        .out_valid(ov1), .out_ready(out_ready[1]), .out_data(od1), .occupancy(occ1)
    );

    pipe_stage_reg #(.WIDTH(16), .RESET_VAL(16'hDEAD), .SKID(1'b1)) u_dut_dv (
        .clk(clk), .rst(rst), .flush(flush[2]),
        .in_valid(in_valid[2]), .in_ready(rdy2), .in_data(in_data[2][15:0]),
        .out_valid(ov2), .out_ready(out_ready[2]), .out_data(od2), .occupancy(occ2)
    );

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: each stage is a FIFO of capacity 2 (SKID=1) or 1 (SKID=0).
    int          cnt [3];
    logic [31:0] mem [3][2];

    function automatic logic [31:0] rv(input int k);
        return (k == 2) ? 32'h0000_DEAD : 32'h0;
    endfunction

    function automatic logic [31:0] dmask(input int k);
        return (k == 2) ? 32'h0000_FFFF : 32'hFFFF_FFFF;
    endfunction

    function automatic logic model_rdy(input int k);
        if (k == 1) return (cnt[k] == 0) || out_ready[k];
        return cnt[k] < 2;
    endfunction

    initial begin
        for (int k = 0; k < 3; k++) cnt[k] = 0;
        forever begin
            @(posedge clk);
            for (int k = 0; k < 3; k++) begin
                logic inf, outf;
                outf = (cnt[k] > 0) && out_ready[k];
                inf  = in_valid[k] && model_rdy(k) && !flush[k];
                if (rst || flush[k]) begin
                    cnt[k] = 0;
                end else begin
                    if (outf) begin
                        mem[k][0] = mem[k][1];
                        cnt[k]--;
                    end
                    if (inf) begin
                        mem[k][cnt[k]] = in_data[k] & dmask(k);
                        cnt[k]++;
                    end
                end
            end
        end
    end

    // Compare process: all outputs of all instances against the model, every cycle.
    initial begin
        forever begin
            @(negedge clk);
            for (int k = 0; k < 3; k++) begin
                logic        a_rdy, a_ov;
                logic [31:0] a_od;
                logic [1:0]  a_occ;
                case (k)
                    0:       begin a_rdy = rdy0; a_ov = ov0; a_od = od0;           a_occ = occ0; end
                    1:       begin a_rdy = rdy1; a_ov = ov1; a_od = od1;           a_occ = occ1; end
                    default: begin a_rdy = rdy2; a_ov = ov2; a_od = {16'h0, od2};  a_occ = occ2; end
                endcase
                check($sformatf("u%0d out_valid", k), {31'h0, a_ov}, {31'h0, cnt[k] > 0});
                check($sformatf("u%0d out_data", k), a_od, (cnt[k] > 0) ? mem[k][0] : rv(k));
                check($sformatf("u%0d occupancy", k), {30'h0, a_occ}, 32'(cnt[k]));
                check($sformatf("u%0d in_ready", k), {31'h0, a_rdy}, {31'h0, model_rdy(k)});
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        flush     = '0;
        in_valid  = '0;
        out_ready = '0;
        for (int k = 0; k < 3; k++) in_data[k] = 32'h0;
    endtask

    initial begin
        rst = 1'b1;
        idle();
        in_valid[0] = 1'b1;
        in_data[0]  = 32'h99;
        tick();
        tick();
        check("rst out_valid", {31'h0, ov0}, 32'h0);
        check("rst out_data", od0, 32'h0);
        check("rst occupancy", {30'h0, occ0}, 32'h0);
        check("rst in_ready s1", {31'h0, rdy0}, 32'h1);
        check("rst in_ready s0", {31'h0, rdy1}, 32'h1);
        check("rst out_data dead", {16'h0, od2}, 32'hDEAD);
        rst = 1'b0;
        idle();

        // Streaming through the SKID=1 stage
        out_ready[0] = 1'b1;
        in_valid[0]  = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            in_data[0] = 32'(i);
            tick();
            check("stream out_data", od0, 32'(i));
            check("stream occupancy", {30'h0, occ0}, 32'h1);
        end
        in_valid[0] = 1'b0;
        tick();
        check("stream drained", {31'h0, ov0}, 32'h0);

        // Backpressure fills the skid entry
        out_ready[0] = 1'b0;
        in_valid[0]  = 1'b1;
        in_data[0]   = 32'hA;
        tick();
        check("bp occ after A", {30'h0, occ0}, 32'h1);
        in_data[0] = 32'hB;
        tick();
        check("bp occ after B", {30'h0, occ0}, 32'h2);
        check("bp in_ready full", {31'h0, rdy0}, 32'h0);
        check("bp head held", od0, 32'hA);
        in_valid[0]  = 1'b0;
        out_ready[0] = 1'b1;
        tick();
        check("bp second out", od0, 32'hB);
        check("bp in_ready back", {31'h0, rdy0}, 32'h1);
        tick();
        check("bp empty valid", {31'h0, ov0}, 32'h0);
        check("bp empty data", od0, 32'h0);

        // Flush from FULL drops both entries and the same-cycle input
        out_ready[0] = 1'b0;
        in_valid[0]  = 1'b1;
        in_data[0]   = 32'hA;
        tick();
        in_data[0] = 32'hB;
        tick();
        flush[0]   = 1'b1;
        in_data[0] = 32'hC;
        tick();
        check("flush occupancy", {30'h0, occ0}, 32'h0);
        check("flush out_valid", {31'h0, ov0}, 32'h0);
        check("flush out_data", od0, 32'h0);
        idle();
        out_ready[0] = 1'b1;
        tick();
        check("flush no 0xC", {31'h0, ov0}, 32'h0);
        idle();

        // SKID=0: combinational in_ready follows out_ready
        in_valid[1] = 1'b1;
        in_data[1]  = 32'h5;
        tick();
        check("s0 main holds 5", od1, 32'h5);
        in_data[1] = 32'h6;
        #1;
        check("s0 in_ready stalled", {31'h0, rdy1}, 32'h0);
        out_ready[1] = 1'b1;
        #1;
        check("s0 in_ready comb", {31'h0, rdy1}, 32'h1);
        tick();
        check("s0 replaced", od1, 32'h6);
        check("s0 occupancy", {30'h0, occ1}, 32'h1);
        idle();
        tick();

        // RESET_VAL=0xDEAD on drain
        in_valid[2]  = 1'b1;
        out_ready[2] = 1'b1;
        in_data[2]   = 32'h1234;
        tick();
        check("dead loaded", {16'h0, od2}, 32'h1234);
        in_valid[2] = 1'b0;
        tick();
        check("dead drained valid", {31'h0, ov2}, 32'h0);
        check("dead drained data", {16'h0, od2}, 32'hDEAD);
        idle();

        // Randomized traffic, checked by the compare process
        for (int c = 0; c < 3000; c++) begin
            rst = ($urandom_range(0, 299) == 0);
            for (int k = 0; k < 3; k++) begin
                in_valid[k]  = ($urandom_range(0, 3) != 0);
                out_ready[k] = ($urandom_range(0, 2) != 0);
                flush[k]     = ($urandom_range(0, 39) == 0);
                in_data[k]   = $urandom;
            end
            tick();
        end
        rst = 1'b0;
        idle();
        tick();
        tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/pipe_stage_reg.md
# pipe_stage_reg

Parametrised elastic pipeline-stage register that carries one WIDTH-bit bundle of control and data fields between two pipeline stages, such as IF/ID, ID/EXE, EXE/MEM or MEM/WB. It replaces the stall/flush-driven register bank with a valid/ready handshake. An optional skid entry breaks the combinational ready path. Flush and reset force a bubble whose payload is RESET_VAL, so a flushed stage presents all-zero control.

## Interface
- WIDTH, 32: payload width in bits; legal range ≥1.
- RESET_VAL, {WIDTH{1'b0}}: payload value loaded on reset, on flush, and whenever the stage drains to empty.
- SKID, 1: 1 gives a 2-entry stage with registered in_ready; 0 gives a 1-entry stage with combinational in_ready.

- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  reset, synchronous, active-high. One clock; reset is synchronous and active-high.
- flush  input  1  synchronous flush; discards all held entries and any same-cycle input.
- in_valid  input  1  upstream has a bundle.
- in_ready  output  1  stage can accept a bundle this cycle.
- in_data  input  WIDTH  upstream bundle.
- out_valid  output  1  out_data holds a valid bundle.
- out_ready  input  1  downstream accepts out_data this cycle.
- out_data  output  WIDTH  head bundle; equals RESET_VAL when out_valid=0.
- occupancy  output  2  number of held entries (0..2; never exceeds 1 when SKID=0).

## Operation
- Handshake events:
  - in_fire = in_valid & in_ready & ~flush.
  - out_fire = out_valid & out_ready.
- Storage:
  - main entry (main_v, main_d) drives out_valid/out_data directly.
  - skid entry (skid_v, skid_d) exists only when SKID=1.
- States (SKID=1): EMPTY (occ 0), ONE (main_v), FULL (main_v & skid_v).
  - EMPTY: in_fire → ONE, main_d←in_data; otherwise stay.
  - ONE:
    - in_fire & out_fire → ONE, main_d←in_data.
    - in_fire & ~out_fire → FULL, skid_d←in_data.
    - ~in_fire & out_fire → EMPTY, main_d←RESET_VAL.
    - neither → hold.
  - FULL:
    - in_ready=0.
    - out_fire → ONE, main_d←skid_d, skid_d←RESET_VAL.
    - otherwise hold.
  - in_ready = ~skid_v. Registered; no combinational path from out_ready.
- SKID=0 (states EMPTY/ONE only):
  - in_ready = ~main_v | out_ready.
  - ONE with in_fire & out_fire → ONE, main_d←in_data.
  - ONE with out_fire only → EMPTY, main_d←RESET_VAL.
  - EMPTY with in_fire → ONE, main_d←in_data.
- Flush (rst=0, flush=1):
  - Next state EMPTY; main_d and skid_d ← RESET_VAL.
  - Any in_fire candidate is dropped.
  - out_fire in the flush cycle still counts downstream: the head is consumed. Downstream treats the flush as its own concern.
- Priority: rst > flush > handshake.
- Ordering: strict FIFO. A bundle accepted later never overtakes an earlier one.
- No bundle is ever duplicated or lost except by flush/rst.

## Timing
- Reset values: out_valid=0, out_data=RESET_VAL, occupancy=0.
  - in_ready=1 for SKID=1.
  - in_ready=1 for SKID=0, since main_v=0.
- Latency: a bundle accepted at edge N appears on out_data/out_valid immediately after edge N, i.e. 1 cycle.
- Throughput: 1 bundle/cycle in steady state with out_ready=1, in both modes.
- SKID=1 backpressure:
  - in_ready falls one cycle after the first stalled acceptance, which fills the skid.
  - in_ready rises the cycle after the first out_fire in FULL.
- in_ready during flush: follows the state formula and is not forced low. The transfer is still discarded.
- rst or flush asserted mid-transfer takes effect at that edge. The next cycle is EMPTY, RESET_VAL output.
- in_data is sampled only on in_fire. Changes while not firing have no effect.

## Test plan
- Reset/empty:
  - Stimulus: rst=1 for 2 cycles, WIDTH=32, RESET_VAL=0.
  - Required: out_valid=0, out_data=0, occupancy=0, in_ready=1; no transfers during rst.
- Streaming, SKID=1:
  - Stimulus: out_ready=1, in_valid=1, in_data=1,2,3,4 on consecutive cycles.
  - Required: out_data=1,2,3,4 one cycle later, back-to-back; occupancy stays 1.
- Backpressure/skid:
  - Stimulus: out_ready=0, send A=0xA, B=0xB.
  - Required: occupancy 1→2; in_ready=0 after B; out_data=0xA held.
  - Then: out_ready=1.
  - Required: 0xA, then 0xB, then out_valid=0 with out_data=0; in_ready=1 the cycle after the 0xA fire.
- Flush:
  - Stimulus: in FULL (0xA,0xB), assert flush with in_valid=1, in_data=0xC.
  - Required: next cycle occupancy=0, out_valid=0, out_data=RESET_VAL; 0xC never appears.
- SKID=0:
  - Stimulus: out_ready=0, main holds 0x5, in_valid=1.
  - Required: in_ready=0.
  - Then: raise out_ready in the same cycle.
  - Required: in_ready=1 combinationally; 0x5 consumed and new data loaded at the same edge.
- RESET_VAL=0xDEAD, WIDTH=16:
  - Stimulus: drain the stage to empty.
  - Required: out_data=0xDEAD when out_valid=0.
